// File: rtl/pz_sweep_source.sv
// Holds the 4-zero/4-pole table and raster-sweeps z=(x,y) over the grid into the difference/log pipeline.
// Latency: start->first point 1 cycle, last transfer->done 1 cycle; the point holds while out_ready is low.
module pz_sweep_source #(
  parameter int                 WIDTH  = 64,
  parameter int                 HEIGHT = 48,
  parameter logic signed [15:0] X0     = -16'sd2048,
  parameter logic signed [15:0] Y0     = -16'sd1536,
  parameter logic signed [15:0] X_STEP = 16'sd64,
  parameter logic signed [15:0] Y_STEP = 16'sd64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cfg_we,
  input  logic [2:0]                  cfg_sel,
  input  logic [31:0]                 cfg_data,
  input  logic                        start,
  input  logic                        abort,
  output logic                        busy,
  output logic                        done,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [15:0]          x,
  output logic signed [15:0]          y,
  output logic [$clog2(WIDTH)-1:0]    col,
  output logic [$clog2(HEIGHT)-1:0]   row,
  output logic                        last,
  output logic [127:0]                zero_flat,
  output logic [127:0]                pole_flat
);

  localparam int CW = $clog2(WIDTH);
  localparam int RW = $clog2(HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0] state;

  assign busy      = (state == S_SWEEP);
  assign out_valid = (state == S_SWEEP);
  assign done      = (state == S_DONE);
  assign last      = out_valid && (col == COL_LAST) && (row == ROW_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      x         <= X0;
      y         <= Y0;
      col       <= '0;
      row       <= '0;
      zero_flat <= '0;
      pole_flat <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // The table only changes here, so it is frozen for the whole sweep.
          if (cfg_we) begin
            if (cfg_sel[2]) pole_flat[{cfg_sel[1:0], 5'b0} +: 32] <= cfg_data;
            else            zero_flat[{cfg_sel[1:0], 5'b0} +: 32] <= cfg_data;
          end
          if (start) state <= S_SWEEP;
        end
        S_SWEEP: begin
          // abort wins over a same-cycle transfer; that point is not consumed.
          if (abort) begin
            state <= S_IDLE;
            x     <= X0;
            y     <= Y0;
            col   <= '0;
            row   <= '0;
          end else if (out_ready) begin
            if (last) begin
              state <= S_DONE;
            end else if (col == COL_LAST) begin
              col <= '0;
              x   <= X0;
              row <= row + 1'b1;
              y   <= y + Y_STEP;
            end else begin
              col <= col + 1'b1;
              x   <= x + X_STEP;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          x     <= X0;
          y     <= Y0;
          col   <= '0;
          row   <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pz_sweep_source.sv
// Bench for pz_sweep_source: default-parameter instance plus a 2x3 instance whose x wraps past +32767.
module tb_pz_sweep_source;

  localparam int W = 64, H = 48, W2 = 2, H2 = 3;
  localparam logic signed [15:0] X0A = -16'sd2048, Y0A = -16'sd1536, X0B = 16'sd32704;
  localparam logic signed [15:0] XS = 16'sd64, YS = 16'sd64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cfg_we, start, abort, out_ready;
  logic [2:0] cfg_sel;
  logic [31:0] cfg_data;
  logic busy, done, out_valid, last;
  logic signed [15:0] x, y;
  logic [5:0] col, row;
  logic [127:0] zero_flat, pole_flat;

  logic rst_b, start_b, ready_b;
  logic busy_b, done_b, valid_b, last_b;
  logic signed [15:0] x_b, y_b;
  logic [0:0] col_b;
  logic [1:0] row_b;
  logic [127:0] zero_b, pole_b;

  pz_sweep_source dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
    .start(start), .abort(abort), .busy(busy), .done(done), .out_valid(out_valid),
    .out_ready(out_ready), .x(x), .y(y), .col(col), .row(row), .last(last),
    .zero_flat(zero_flat), .pole_flat(pole_flat)
  );

  pz_sweep_source #(.WIDTH(W2), .HEIGHT(H2), .X0(X0B)) dut_b (
    .clk(clk), .rst(rst_b), .cfg_we(1'b0), .cfg_sel(3'd0), .cfg_data(32'd0),
    .start(start_b), .abort(1'b0), .busy(busy_b), .done(done_b), .out_valid(valid_b),
    .out_ready(ready_b), .x(x_b), .y(y_b), .col(col_b), .row(row_b), .last(last_b),
    .zero_flat(zero_b), .pole_flat(pole_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a sweep is just an index into the ordered point list of the grid.
  bit          m_init[2];
  bit          m_sw[2];
  bit          m_dn[2];
  int          m_idx[2];
  logic [31:0] m_tbl[2][8];

  task automatic model_cycle(input int u, input int w, input int h, input logic signed [15:0] x0,
                             input logic r, input logic we, input logic [2:0] sel, input logic [31:0] dat,
                             input logic st, input logic ab, input logic rdy,
                             input logic o_busy, input logic o_done, input logic o_vld, input logic o_last,
                             input logic signed [15:0] ox, input logic signed [15:0] oy,
                             input int ocol, input int orow, input logic [127:0] zf, input logic [127:0] pf);
    int c, rr;
    logic [127:0] ez, ep;
    logic [15:0] ex, ey;
    if (m_init[u]) begin
      for (int i = 0; i < 4; i++) begin
        ez[32*i +: 32] = m_tbl[u][i];
        ep[32*i +: 32] = m_tbl[u][i+4];
      end
      chk("busy", o_busy, m_sw[u]);
      chk("out_valid", o_vld, m_sw[u]);
      chk("done", o_done, m_dn[u]);
      chk("zero_flat", zf, ez);
      chk("pole_flat", pf, ep);
      if (!m_dn[u]) begin
        c  = m_sw[u] ? m_idx[u] % w : 0;
        rr = m_sw[u] ? m_idx[u] / w : 0;
        ex = 16'(int'(x0) + c * int'(XS));
        ey = 16'(int'(Y0A) + rr * int'(YS));
        chk("x", $unsigned(ox), ex);
        chk("y", $unsigned(oy), ey);
        chk("col", ocol, c);
        chk("row", orow, rr);
        chk("last", o_last, m_sw[u] && (m_idx[u] == w*h-1));
      end
    end
    if (r) begin
      m_init[u] = 1'b1; m_sw[u] = 1'b0; m_dn[u] = 1'b0; m_idx[u] = 0;
      for (int i = 0; i < 8; i++) m_tbl[u][i] = '0;
    end else if (!m_init[u]) begin
      m_idx[u] = 0;
    end else if (m_dn[u]) begin
      m_dn[u] = 1'b0;
    end else if (!m_sw[u]) begin
      if (we) m_tbl[u][sel] = dat;
      if (st) begin m_sw[u] = 1'b1; m_idx[u] = 0; end
    end else if (ab) begin
      m_sw[u] = 1'b0;
    end else if (rdy) begin
      if (m_idx[u] == w*h-1) begin m_sw[u] = 1'b0; m_dn[u] = 1'b1; end
      else m_idx[u]++;
    end
  endtask

  int xcnt = 0, lastcnt = 0, donecnt = 0, xcnt_b = 0;
  logic signed [15:0] fx, fy, lx, ly;

  always @(negedge clk) begin
    model_cycle(0, W, H, X0A, rst, cfg_we, cfg_sel, cfg_data, start, abort, out_ready,
                busy, done, out_valid, last, x, y, int'(col), int'(row), zero_flat, pole_flat);
    model_cycle(1, W2, H2, X0B, rst_b, 1'b0, 3'd0, 32'd0, start_b, 1'b0, ready_b,
                busy_b, done_b, valid_b, last_b, x_b, y_b, int'(col_b), int'(row_b), zero_b, pole_b);
    if (!rst && out_valid && out_ready && !abort) begin
      xcnt++;
      if (xcnt == 1) begin fx = x; fy = y; end
      lx = x; ly = y;
      if (last) lastcnt++;
    end
    if (done) donecnt++;
    if (!rst_b && valid_b && ready_b) xcnt_b++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: ready always high with a table write attempted mid-sweep; mode 1: random backpressure
  task automatic run_sweep(input int mode);
    int n, d0;
    xcnt = 0; lastcnt = 0; d0 = donecnt; n = 0;
    start = 1'b1; out_ready = 1'b1;
    tick();
    start = 1'b0;
    while (!done && n < 20000) begin
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      cfg_we = (mode == 0 && n == 10);
      cfg_sel = 3'd7; cfg_data = 32'h1234_5678;
      tick();
      n++;
    end
    cfg_we = 1'b0;
    chk("sweep_finished", n < 20000, 1'b1);
    chk("transfer_count", xcnt, W*H);
    chk("last_count", lastcnt, 1);
    chk("first_x", $unsigned(fx), 16'hF800);
    chk("first_y", $unsigned(fy), 16'hFA00);
    chk("last_x", $unsigned(lx), 16'h07C0);
    chk("last_y", $unsigned(ly), 16'h05C0);
    tick();
    chk("done_pulses", donecnt - d0, 1);
    chk("busy_after", busy, 1'b0);
  endtask

  initial begin
    int n;
    rst = 1'b1; cfg_we = 1'b0; cfg_sel = '0; cfg_data = '0; start = 1'b0; abort = 1'b0; out_ready = 1'b0;
    rst_b = 1'b1; start_b = 1'b0; ready_b = 1'b0;
    tick(); tick();
    chk("reset_valid", out_valid, 1'b0);
    chk("reset_x", $unsigned(x), 16'hF800);
    rst = 1'b0; rst_b = 1'b0;
    tick();

    cfg_we = 1'b1; cfg_sel = 3'd0; cfg_data = 32'h0100_FF00;
    tick();
    cfg_sel = 3'd5; cfg_data = 32'h8000_7FFF;
    tick();
    cfg_we = 1'b0;
    chk("load_zero0", zero_flat[31:0], 32'h0100_FF00);
    chk("load_pole1", pole_flat[63:32], 32'h8000_7FFF);
    chk("load_zero_rest", zero_flat[127:32], '0);
    chk("load_pole_rest", {pole_flat[127:64], pole_flat[31:0]}, '0);

    run_sweep(0);
    chk("frozen_pole3", pole_flat[127:96], 32'h0);
    run_sweep(1);

    cfg_we = 1'b1; cfg_sel = 3'd7; cfg_data = 32'h1234_5678; start = 1'b1; out_ready = 1'b1;
    xcnt = 0;
    tick();
    cfg_we = 1'b0; start = 1'b0;
    chk("same_cycle_valid", out_valid, 1'b1);
    chk("same_cycle_pole3", pole_flat[127:96], 32'h1234_5678);
    n = 0;
    while (xcnt < 99 && n < 500) begin tick(); n++; end
    chk("abort_reached", xcnt, 99);
    abort = 1'b1; n = donecnt;
    tick();
    abort = 1'b0;
    chk("abort_valid", out_valid, 1'b0);
    chk("abort_not_consumed", xcnt, 99);
    tick(); tick();
    chk("abort_no_done", donecnt, n);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("restart_x", $unsigned(x), 16'hF800);
    chk("restart_y", $unsigned(y), 16'hFA00);
    chk("restart_colrow", {col, row}, 12'h0);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    start_b = 1'b1; ready_b = 1'b1;
    tick();
    start_b = 1'b0;
    chk("wrap_x0", $unsigned(x_b), 16'h7FC0);
    tick();
    chk("wrap_x1", $unsigned(x_b), 16'h8000);
    chk("wrap_col1", col_b, 1'b1);
    n = 0;
    while (xcnt_b < 4 && n < 50) begin tick(); n++; end
    chk("wrap_reached5", xcnt_b, 4);
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("rst_mid_valid", valid_b, 1'b0);
    chk("rst_mid_busy", busy_b, 1'b0);
    chk("rst_mid_xy", {x_b, y_b}, 32'h7FC0_FA00);
    chk("rst_mid_colrow_last", {col_b, row_b, last_b}, 4'h0);
    tick();
    chk("rst_mid_no_done", done_b, 1'b0);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pz_sweep_source.md
Name: pz_sweep_source

Overview:
- Producer side of the complex-difference stage in the log-magnitude datapath.
- Holds the 4-zero / 4-pole table, loaded through a simple write port, and presents it as stable parallel words.
- Raster-sweeps the evaluation point z = (x, y) over a WIDTH x HEIGHT grid, one point per valid/ready transfer, into the difference/log pipeline.
- Table is frozen for the whole sweep.

Parameters:
WIDTH, 64, grid columns (>=2)
HEIGHT, 48, grid rows (>=2)
X0, -16'sd2048, signed x of column 0
Y0, -16'sd1536, signed y of row 0
X_STEP, 16'sd64, signed x increment per column
Y_STEP, 16'sd64, signed y increment per row

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
cfg_we  in  1  table write strobe
cfg_sel  in  3  0-3 select zero[0..3], 4-7 select pole[0..3]
cfg_data  in  32  {re[31:16], im[15:0]}, signed halves
start  in  1  begin sweep (level sampled)
abort  in  1  terminate sweep
busy  out  1  high in SWEEP
done  out  1  one-cycle pulse after last point transferred
out_valid  out  1  point valid
out_ready  in  1  downstream accepts
x  out  16  signed real part of current point
y  out  16  signed imag part of current point
col  out  clog2(WIDTH)  current column index
row  out  clog2(HEIGHT)  current row index
last  out  1  high with the final point (col=WIDTH-1, row=HEIGHT-1)
zero_flat  out  128  zero[i] at bits [32i+31:32i]
pole_flat  out  128  pole[i] at bits [32i+31:32i]

Behaviour:
- Reset (rst=1 at edge): FSM=IDLE; busy=0, done=0, out_valid=0, last=0; x=X0, y=Y0, col=0, row=0; all 8 table words=0. Reset mid-sweep abandons the sweep with no done pulse.
- States: IDLE, SWEEP, DONE.
- Table writes:
  - Accepted only in IDLE; cfg_we in SWEEP or DONE is ignored (no queueing).
  - A write lands at the next edge. zero_flat/pole_flat are registered outputs and change only on accepted writes.
- IDLE -> SWEEP: start=1 at an edge.
  - The next cycle has busy=1, out_valid=1, x=X0, y=Y0, col=row=0.
  - cfg_we and start in the same cycle: the write commits on that edge and the first point already sees the new table.
- SWEEP:
  - Transfer = out_valid & out_ready.
  - Without a transfer, x/y/col/row/last hold.
  - Transfer with col<WIDTH-1: col+1, x+=X_STEP.
  - Transfer with col=WIDTH-1 and row<HEIGHT-1: col=0, x=X0, row+1, y+=Y_STEP.
  - Transfer with last=1: go to DONE; out_valid=0 next cycle.
  - out_valid stays high continuously through the sweep, so back-to-back transfers give 1 point/cycle.
- x/y arithmetic: 16-bit two's complement, wraps modulo 2^16 with no saturation. Accumulated by adding the step; no multiply.
- DONE: done=1 for exactly one cycle, busy=0, then IDLE. x/y/col/row reload X0/Y0/0/0 on entering IDLE.
- abort=1 in SWEEP: IDLE next cycle, out_valid=0, no done pulse. abort has priority over a same-cycle transfer; that point counts as not consumed. abort outside SWEEP has no effect.
- start in SWEEP or DONE: ignored.
- Total transfers per sweep = WIDTH*HEIGHT exactly.
- Latency from start to first valid: 1 cycle. From last transfer to done: 1 cycle.

Test Plan:
- Reset then load: write sel=0 data 32'h0100_FF00 and sel=5 data 32'h8000_7FFF -> zero_flat[31:0]=0100FF00, pole_flat[63:32]=80007FFF, all other words 0.
- Full sweep, defaults, out_ready=1:
  - start -> 3072 transfers, first (x,y)=(-2048,-1536), last (x,y)=(1984,1472).
  - last asserted only on transfer 3072; done pulses 1 cycle later; busy low after.
- Backpressure: toggle out_ready pseudo-randomly -> x/y/col/row stable whenever valid&!ready, no point skipped or duplicated (scoreboard of 3072 ordered points).
- Frozen table: cfg_we sel=7 data 32'h1234_5678 mid-sweep -> pole_flat unchanged. The same write in IDLE with start in the same cycle -> new value present on the first valid point.
- Abort: abort at transfer 100 with out_ready=1 -> out_valid=0 next cycle, no done. The next start restarts at (-2048,-1536), col=row=0.
- Wrap: X0=16'sd32704, X_STEP=64, WIDTH=2 -> column 1 gives x=-32768. Assert rst at transfer 5 -> all outputs at reset values next cycle, no done.
